// File: rtl/adda_capture_player.sv
// AD9280 -> AD9708 sample path with live passthrough, sawtooth generator,
// threshold-triggered capture into block RAM and looped playback.
//
// state        | meaning
// ST_IDLE      | no capture in progress, buffer contents not claimed
// ST_WAIT_TRIG | armed, waiting for a rising crossing of i_trig_level
// ST_FILL      | storing consecutive samples after the trigger
// ST_DONE      | full buffer captured and valid for playback
module adda_capture_player #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [1:0]        i_mode,
    input  logic              i_arm,
    input  logic [DATA_W-1:0] i_trig_level,
    input  logic [DATA_W-1:0] i_ad_data,
    output logic [DATA_W-1:0] o_da_data,
    output logic [7:0]        o_led,
    output logic              o_busy,
    output logic              o_capture_done
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = {DEPTH_LOG2{1'b1}};

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_SAW     = 2'd1;
    localparam logic [1:0] MODE_CAPTURE = 2'd2;
    localparam logic [1:0] MODE_PLAY    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_TRIG,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t                state;
    logic [1:0]            mode_q;
    logic [DATA_W-1:0]     ad_q;
    logic [DATA_W-1:0]     ad_prev;
    logic [DATA_W-1:0]     saw;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  buf_valid;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     mem_rdata;

    logic                  mode_entry;
    logic                  trig_hit;
    logic                  arm_ok;
    logic [DATA_W-1:0]     saw_next;
    logic [DEPTH_LOG2-1:0] rd_next;
    logic [DATA_W-1:0]     da_next;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;

    always_comb begin
        mode_entry = (i_mode != mode_q);
        trig_hit   = (ad_prev < i_trig_level) && (ad_q >= i_trig_level);
        arm_ok     = i_arm && (i_mode == MODE_CAPTURE);
        saw_next   = mode_entry ? '0 : saw + DATA_W'(1);
        rd_next    = mode_entry ? '0 : rd_addr + DEPTH_LOG2'(1);

        case (i_mode)
            MODE_PASS:    da_next = ad_q;
            MODE_SAW:     da_next = saw_next;
            MODE_CAPTURE: da_next = ad_q;
            MODE_PLAY:    da_next = buf_valid ? mem_rdata : '0;
            default:      da_next = ad_q;
        endcase
    end

    // Writes are suppressed under reset and on the abort cycle of a mode change.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        if (!i_reset && !mode_entry) begin
            if (state == ST_WAIT_TRIG && trig_hit) begin
                mem_we    = 1'b1;
                mem_waddr = '0;
            end else if (state == ST_FILL) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        ad_q    <= i_ad_data;
        ad_prev <= ad_q;
    end

    // Read address is the next rd_addr so mem[0] lands in mem_rdata on the entry edge.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= ad_q;
        end
        mem_rdata <= mem[rd_next];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            mode_q         <= '0;
            saw            <= '0;
            wr_addr        <= '0;
            rd_addr        <= '0;
            buf_valid      <= 1'b0;
            o_da_data      <= '0;
            o_led          <= '0;
            o_busy         <= 1'b0;
            o_capture_done <= 1'b0;
        end else begin
            mode_q    <= i_mode;
            saw       <= saw_next;
            rd_addr   <= rd_next;
            o_da_data <= da_next;
            o_led     <= da_next[DATA_W-1 -: 8];

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm_ok) begin
                        state          <= ST_WAIT_TRIG;
                        o_busy         <= 1'b1;
                        o_capture_done <= 1'b0;
                        buf_valid      <= 1'b0;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (mode_entry) begin
                        state          <= ST_IDLE;
                        o_busy         <= 1'b0;
                        o_capture_done <= 1'b0;
                        buf_valid      <= 1'b0;
                    end else if (trig_hit) begin
                        wr_addr <= DEPTH_LOG2'(1);
                        state   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mode_entry) begin
                        state          <= ST_IDLE;
                        o_busy         <= 1'b0;
                        o_capture_done <= 1'b0;
                        buf_valid      <= 1'b0;
                    end else begin
                        wr_addr <= wr_addr + DEPTH_LOG2'(1);
                        if (wr_addr == LAST_ADDR) begin
                            state          <= ST_DONE;
                            o_busy         <= 1'b0;
                            o_capture_done <= 1'b1;
                            buf_valid      <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adda_capture_player.sv
// Scoreboard bench for adda_capture_player: driver pushes reference-model
// expectations per edge, a negedge monitor pops and compares.
module tb_adda_capture_player;

    localparam int DATA_W     = 8;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic [1:0]        i_mode;
    logic              i_arm;
    logic [DATA_W-1:0] i_trig_level;
    logic [DATA_W-1:0] i_ad_data;
    logic [DATA_W-1:0] o_da_data;
    logic [7:0]        o_led;
    logic              o_busy;
    logic              o_capture_done;

    always #5 i_clk = ~i_clk;

    adda_capture_player #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_mode         (i_mode),
        .i_arm          (i_arm),
        .i_trig_level   (i_trig_level),
        .i_ad_data      (i_ad_data),
        .o_da_data      (o_da_data),
        .o_led          (o_led),
        .o_busy         (o_busy),
        .o_capture_done (o_capture_done)
    );

    typedef struct packed {
        logic       chk_da;
        logic [7:0] da;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   running  = 1'b1;
    int   mon_cyc  = 0;
    exp_t mon_e;

    // reference model state
    logic [7:0] hist_d1 = 8'h00;
    logic [7:0] hist_d2 = 8'h00;
    int         cyc = 0;
    int         prev_mode = 0;
    int         saw_entry = 0;
    int         pb_entry = 0;
    bit         m_wait = 0, m_fill = 0, m_done = 0, m_valid = 0;
    logic [7:0] cap[$];

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, mon_cyc, act, expv);
        end
    endfunction

    always @(negedge i_clk) begin
        if (running) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow cyc=%0d actual=empty expected=entry", mon_cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk_da) begin
                    chk("da_data", o_da_data, mon_e.da);
                    chk("led", o_led, mon_e.da);
                end
                chk("busy", {7'd0, o_busy}, {7'd0, mon_e.busy});
                chk("capture_done", {7'd0, o_capture_done}, {7'd0, mon_e.done});
            end
            mon_cyc++;
        end
    end

    // Applies one cycle of inputs, predicts the outputs after the coming edge.
    task automatic step(input bit rst, input logic [1:0] mode, input bit arm,
                        input logic [7:0] lvl, input logic [7:0] ad);
        exp_t e;
        bit   entry;
        bit   valid_before;
        i_reset      = rst;
        i_mode       = mode;
        i_arm        = arm;
        i_trig_level = lvl;
        i_ad_data    = ad;
        e.chk_da = 1'b1;
        e.da     = 8'h00;
        if (rst) begin
            m_wait  = 0;
            m_fill  = 0;
            m_done  = 0;
            m_valid = 0;
        end else begin
            entry        = (int'(mode) != prev_mode);
            valid_before = m_valid;
            if (entry && mode == 2'd1) saw_entry = cyc;
            if (entry && mode == 2'd3) pb_entry = cyc;

            if ((m_wait || m_fill) && entry) begin
                m_wait  = 0;
                m_fill  = 0;
                m_done  = 0;
                m_valid = 0;
            end else if (m_wait) begin
                if (hist_d2 < lvl && hist_d1 >= lvl) begin
                    cap.delete();
                    cap.push_back(hist_d1);
                    m_wait = 0;
                    m_fill = 1;
                end
            end else if (m_fill) begin
                cap.push_back(hist_d1);
                if (cap.size() == DEPTH) begin
                    m_fill  = 0;
                    m_done  = 1;
                    m_valid = 1;
                end
            end else if (mode == 2'd2 && arm) begin
                m_wait  = 1;
                m_done  = 0;
                m_valid = 0;
            end

            case (mode)
                2'd1: e.da = 8'((cyc - saw_entry) % 256);
                2'd3: begin
                    if (!valid_before) e.da = 8'h00;
                    else if (cyc == pb_entry) e.chk_da = 1'b0;
                    else e.da = cap[(cyc - pb_entry - 1) % DEPTH];
                end
                default: e.da = hist_d1;
            endcase
        end
        e.busy = m_wait || m_fill;
        e.done = m_done;
        sb_q.push_back(e);
        prev_mode = rst ? 0 : int'(mode);
        hist_d2   = hist_d1;
        hist_d1   = ad;
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [1:0] r_mode;
    int         r_len;
    logic [7:0] r_lvl;
    bit         r_arm;
    bit         r_rst;

    initial begin
        repeat (3) step(1, 2'd0, 0, 8'h80, 8'h00);

        // passthrough ramp
        for (int i = 0; i < 256; i++) step(0, 2'd0, 0, 8'h80, 8'(i));

        // sawtooth wrap and restart
        for (int i = 0; i < 260; i++) step(0, 2'd1, 0, 8'h80, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 8'h80, 8'h55);
        for (int i = 0; i < 10; i++) step(0, 2'd1, 0, 8'h80, 8'h00);

        // playback with no capture
        for (int i = 0; i < 20; i++) step(0, 2'd3, 0, 8'h80, 8'h00);

        // triggered capture then playback
        for (int i = 0; i < 3; i++) step(0, 2'd2, 0, 8'h80, 8'h10);
        step(0, 2'd2, 1, 8'h80, 8'h10);
        step(0, 2'd2, 0, 8'h80, 8'h10);
        step(0, 2'd2, 0, 8'h80, 8'h7F);
        for (int i = 0; i < 24; i++) step(0, 2'd2, 0, 8'h80, 8'(8'h80 + i));
        for (int i = 0; i < 40; i++) step(0, 2'd3, 0, 8'h80, 8'h00);

        // no false trigger while already above level
        step(0, 2'd2, 1, 8'h80, 8'h90);
        for (int i = 0; i < 10; i++) step(0, 2'd2, 0, 8'h80, 8'h90);
        step(0, 2'd2, 0, 8'h80, 8'h20);
        step(0, 2'd2, 0, 8'h80, 8'h90);
        for (int i = 0; i < 20; i++) step(0, 2'd2, 0, 8'h80, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 20; i++) step(0, 2'd3, 0, 8'h80, 8'h00);

        // abort mid-fill
        step(0, 2'd2, 0, 8'h80, 8'h10);
        step(0, 2'd2, 1, 8'h80, 8'h10);
        step(0, 2'd2, 0, 8'h80, 8'h10);
        step(0, 2'd2, 0, 8'h80, 8'hA0);
        for (int i = 0; i < 5; i++) step(0, 2'd2, 0, 8'h80, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 8'h80, 8'h33);
        for (int i = 0; i < 20; i++) step(0, 2'd3, 0, 8'h80, 8'h00);

        // capture, playback, reset mid-playback
        step(0, 2'd2, 1, 8'h40, 8'h00);
        step(0, 2'd2, 0, 8'h40, 8'h00);
        for (int i = 0; i < 20; i++) step(0, 2'd2, 0, 8'h40, 8'(8'h40 + 3 * i));
        for (int i = 0; i < 10; i++) step(0, 2'd3, 0, 8'h40, 8'h00);
        step(1, 2'd3, 0, 8'h40, 8'h00);
        for (int i = 0; i < 10; i++) step(0, 2'd3, 0, 8'h40, 8'h00);

        // randomized segments
        for (int seg = 0; seg < 60; seg++) begin
            r_mode = 2'($urandom_range(0, 3));
            r_len  = $urandom_range(1, 50);
            r_lvl  = 8'($urandom_range(0, 255));
            for (int k = 0; k < r_len; k++) begin
                r_arm = ($urandom_range(0, 7) == 0);
                r_rst = ($urandom_range(0, 299) == 0);
                step(r_rst, r_mode, r_arm, r_lvl, 8'($urandom_range(0, 255)));
            end
        end

        @(negedge i_clk);
        #1;
        running = 1'b0;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover actual=%0d expected=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adda_capture_player.md
Name: adda_capture_player

Overview:
Parametrised successor to the board-level AD-to-DA passthrough path. Sits between the AD9280 input pins and the AD9708 output pins, clocked by the common converter clock. Selects one of four run-time modes: live passthrough, internal sawtooth generator, triggered capture into an on-chip buffer, or looped playback of that buffer. Mirrors the current DA value onto the board LEDs.

Parameters:
DATA_W, 8, converter sample width in bits; must be >= 8.
DEPTH_LOG2, 10, log2 of the capture buffer depth; DEPTH = 2**DEPTH_LOG2 samples.

Ports:
i_clk  in  1  converter/system clock; all logic is on its rising edge.
i_reset  in  1  synchronous, active-high reset.
i_mode  in  2  mode select: 0 passthrough, 1 sawtooth, 2 capture, 3 playback.
i_arm  in  1  single-cycle pulse; arms a capture (mode 2 only).
i_trig_level  in  DATA_W  unsigned trigger threshold.
i_ad_data  in  DATA_W  raw ADC sample from the J2 AD port.
o_da_data  out  DATA_W  registered DAC sample to the J2 DA port.
o_led  out  8  registered copy of o_da_data[DATA_W-1:DATA_W-8].
o_busy  out  1  high while capture is armed or filling.
o_capture_done  out  1  high once a full buffer has been captured.

Behaviour:
- Reset: o_da_data=0, o_led=0, o_busy=0, o_capture_done=0, capture FSM=IDLE, sawtooth=0, read/write addresses=0, buf_valid=0, mode_q=0.
- Input stage: ad_q <= i_ad_data and ad_prev <= ad_q every cycle, in all modes.
- mode_q <= i_mode every cycle. A "mode entry" is a cycle where i_mode != mode_q.
- o_led <= top 8 bits of the o_da_data next value. o_led therefore equals o_da_data's top 8 bits in the same cycle.
- Mode 0 (passthrough): o_da_data <= ad_q. Latency is 2 cycles: o_da_data(t+2) = i_ad_data(t).
- Mode 1 (sawtooth):
  - saw clears to 0 on mode entry, otherwise increments by 1 per cycle, wrapping from 2**DATA_W-1 to 0.
  - o_da_data <= saw. The first value after entry is 0, then 1, 2, ...
- Mode 2 (capture): o_da_data follows passthrough timing. The capture FSM runs as follows:
  - IDLE: i_arm=1 -> WAIT_TRIG. Entering WAIT_TRIG clears o_capture_done and buf_valid and sets o_busy=1.
  - WAIT_TRIG: a trigger is the rising crossing ad_prev < i_trig_level AND ad_q >= i_trig_level (unsigned). On trigger, write ad_q to mem[0], set wr_addr=1, go to FILL.
  - FILL: write ad_q to mem[wr_addr] each cycle and increment wr_addr. After writing address DEPTH-1, go to DONE with o_busy=0, o_capture_done=1, buf_valid=1.
  - DONE: hold. i_arm=1 -> WAIT_TRIG (re-arm).
  - i_arm is ignored while in WAIT_TRIG or FILL, and whenever i_mode != 2.
- Abort: a mode change while in WAIT_TRIG or FILL returns the FSM to IDLE with o_busy=0, o_capture_done=0, buf_valid=0. Buffer contents are then undefined.
- A mode change from DONE keeps buf_valid=1 and o_capture_done=1.
- Mode 3 (playback):
  - rd_addr clears to 0 on mode entry, otherwise increments each cycle and wraps from DEPTH-1 to 0.
  - Buffer read has 1-cycle latency; o_da_data <= mem_rdata. mem[0] appears on o_da_data 2 cycles after the entry cycle, then samples follow consecutively.
  - If buf_valid=0, o_da_data <= 0.
- Buffer: single-clock simple dual-port RAM, DEPTH x DATA_W, inferable as ECP5 block RAM. Contents are not reset.
- i_reset has priority over all events, including mid-FILL and mid-playback.

Test Plan:
- Passthrough: mode 0, drive i_ad_data ramp 0x00..0xFF one step per cycle -> o_da_data equals the ramp delayed 2 cycles; o_led equals o_da_data.
- Sawtooth wrap: mode 1 for 260 cycles -> o_da_data runs 0..0xFF, then 0x00, 0x01, ...; switch to mode 0 and back -> restarts at 0.
- Triggered capture: DEPTH_LOG2=4, level 0x80, arm, then drive 0x10,0x7F,0x80,0x81,... -> o_busy=1 from the cycle after arm; mem[0]=0x80; o_capture_done rises exactly 16 samples after trigger; o_busy falls in the same cycle.
- No false trigger: arm, hold input at 0x90 (already above level) -> remains in WAIT_TRIG; drop to 0x20 then 0x90 -> triggers on the 0x90.
- Playback: after the above capture, mode 3 -> o_da_data replays the 16 captured samples starting 2 cycles after entry, looping from index 15 to 0; with no prior capture -> o_da_data stays 0.
- Abort/reset: switch to mode 0 mid-FILL -> o_busy=0, o_capture_done=0, and a later mode 3 outputs 0. Assert i_reset during playback -> all outputs 0 on the next edge.
